wall_scan_ctrl: RTL and testbench
=================================

# wall_scan_ctrl

Per-frame scheduler that sweeps the wall tile map and decides which of the hero's four moves are blocked. On a `start` pulse it latches the hero position, walks every grid cell through an external 1-bit tile ROM with one-cycle read latency, tests each wall tile against the hero box shifted by one movement step, and publishes four registered "blocked" flags with a `done` pulse. It sits between the wall tile map and the hero movement logic, replacing per-cycle free-running collision checks with one deterministic sweep per frame.

## Interface
- `GRID_W`, 15, tile columns
- `GRID_H`, 10, tile rows
- `SQUARE_SIDE`, 60, tile and hero side in pixels
- `X_OFFSET`, 62, pixel x of column 0
- `Y_OFFSET`, 108, pixel y of row 0
- `MOVE_STEP`, 4, pixels per hero move that is checked
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  sweep request; sampled only in IDLE
- `hero_x_pos`  in  12  hero top-left x; latched on accepted `start`
- `hero_y_pos`  in  12  hero top-left y; latched on accepted `start`
- `map_en`  out  1  tile read strobe
- `map_col`  out  4  tile column address
- `map_row`  out  4  tile row address
- `map_data`  in  1  wall bit for the address issued in the previous cycle
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse; flags updated this cycle
- `block_left`, `block_right`, `block_up`, `block_down`  out  1 each  move blocked

## Operation
- States: IDLE, SCAN, FLUSH.
- IDLE: `busy`=0, `map_en`=0, col=row=0. If `start`=1: latch hero x/y, clear the internal accumulators, go to SCAN.
- SCAN: `map_en`=1. Address col/row comes from registers. Col increments every cycle. On reaching GRID_W-1, col wraps to 0 and row increments. After address (GRID_W-1, GRID_H-1) is issued, go to FLUSH.
- A one-cycle delayed copy of col/row plus a valid bit pairs `map_data` with its tile. When the copy is valid and `map_data`=1, the four move tests are run and the results are ORed into the accumulators.
- FLUSH: `map_en`=0. Evaluate the last tile. Then write accumulators ORed with the last result to `block_*`, set `done`=1 for the next cycle, and return to IDLE.
- Tile box: tx = X_OFFSET + SQUARE_SIDE·col, ty = Y_OFFSET + SQUARE_SIDE·row.
- All arithmetic is 13-bit unsigned. No subtraction is used, so no underflow occurs.
- Overlap is strict; touching edges do not overlap.
- X-overlap at current position: hx < tx+S and hx+S > tx. Y-overlap is the same form with hy, ty.
- left: (hx < tx+S+STEP) and (hx+S > tx+STEP) and y-overlap.
- right: (hx+STEP < tx+S) and (hx+STEP+S > tx) and y-overlap.
- up: x-overlap and (hy < ty+S+STEP) and (hy+S > ty+STEP).
- down: x-overlap and (hy+STEP < ty+S) and (hy+STEP+S > ty).
- `block_*` hold their value from one `done` to the next. They never change mid-sweep.

## Timing
- Reset values: state IDLE; `busy`, `done`, `map_en`, `map_col`, `map_row`, all `block_*` = 0; accumulators cleared.
- Start accepted at cycle 0.
- Cycles 1..N (N = GRID_W·GRID_H = 150): SCAN, addresses 0..N-1 in row-major order.
- Cycle N+1: FLUSH.
- Cycle N+2: `done`=1, flags valid, state IDLE.
- `busy`=1 on cycles 1..N+1.
- `start` during SCAN or FLUSH is ignored and not queued.
- `start` in the `done` cycle is accepted, because the block is already in IDLE.
- Hero inputs changing during a sweep have no effect.
- `rst` mid-sweep: the block returns to the reset state and no `done` is issued.

## Configuration
- `WALL_SCAN_BORDER_EN` defined: playfield edges act as walls. The edge terms are ORed in at FLUSH:
  - left if hx < X_OFFSET+STEP
  - right if hx+S+STEP > X_OFFSET+GRID_W·S
  - up if hy < Y_OFFSET+STEP
  - down if hy+S+STEP > Y_OFFSET+GRID_H·S
- Not defined: only map tiles block movement. Timing is identical in both builds.

## Test plan
- All-zero map, hero (300,300), start at cycle 0 → `busy` on cycles 1..151; `done` only at cycle 152; all flags 0; `map_col`/`map_row` sequence 0..14 / 0..9.
- Wall at (col 1,row 1) = box (122,168); hero (62,168) → right=1, left/up/down=0.
- Wall at (col 0,row 1) = box (62,168); hero (62,108) → down=1, others 0. Then hero (62,228) on the next sweep → up=1 only.
- Macro defined, empty map, hero (62,108) → left=1, up=1, right=0, down=0. Same stimulus without the macro → all 0.
- `start` pulsed again at cycle 50 of a sweep → ignored; `done` still at 152. `start` held high at cycle 152 → new sweep, next `done` at 304.
- `rst` asserted at cycle 80 with a wall under the hero → all outputs 0 next cycle, no `done`. Flags stay 0 until a new sweep completes.

Source files
------------

// File: rtl/wall_scan_ctrl.sv
// Sweeps the wall tile map once per start pulse and latches which of the four hero moves are blocked.
// Optional WALL_SCAN_BORDER_EN: the playfield edges also block movement.
module wall_scan_ctrl #(
  parameter int GRID_W      = 15,
  parameter int GRID_H      = 10,
  parameter int SQUARE_SIDE = 60,
  parameter int X_OFFSET    = 62,
  parameter int Y_OFFSET    = 108,
  parameter int MOVE_STEP   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] hero_x_pos,
  input  logic [11:0] hero_y_pos,
  output logic        map_en,
  output logic [3:0]  map_col,
  output logic [3:0]  map_row,
  input  logic        map_data,
  output logic        busy,
  output logic        done,
  output logic        block_left,
  output logic        block_right,
  output logic        block_up,
  output logic        block_down
);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

  localparam logic [3:0]  COL_LAST = 4'(GRID_W - 1);
  localparam logic [3:0]  ROW_LAST = 4'(GRID_H - 1);
  localparam logic [12:0] S        = 13'(SQUARE_SIDE);
  localparam logic [12:0] STEP     = 13'(MOVE_STEP);
  localparam logic [12:0] XO       = 13'(X_OFFSET);
  localparam logic [12:0] YO       = 13'(Y_OFFSET);

  state_t      state, state_nxt;
  logic [3:0]  col, row, d_col, d_row;
  logic        d_vld;
  logic [12:0] hx, hy, tx, ty;
  logic [3:0]  acc, flags, hit, border;  // bit order {left, right, up, down}
  logic        last_tile, x_ov, y_ov;

  assign last_tile = (col == COL_LAST) && (row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (last_tile) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    map_en = (state == SCAN);
  end

  assign map_col = col;
  assign map_row = row;

  // Tile under test is the one addressed in the previous cycle, paired with map_data now.
  assign tx   = XO + S * {9'd0, d_col};
  assign ty   = YO + S * {9'd0, d_row};
  assign x_ov = (hx < tx + S) && (hx + S > tx);
  assign y_ov = (hy < ty + S) && (hy + S > ty);

  always_comb begin
    hit = 4'b0;
    if (d_vld && map_data) begin
      hit[3] = (hx < tx + S + STEP) && (hx + S > tx + STEP) && y_ov;
      hit[2] = (hx + STEP < tx + S) && (hx + STEP + S > tx) && y_ov;
      hit[1] = x_ov && (hy < ty + S + STEP) && (hy + S > ty + STEP);
      hit[0] = x_ov && (hy + STEP < ty + S) && (hy + STEP + S > ty);
    end
  end

`ifdef WALL_SCAN_BORDER_EN
  localparam logic [12:0] X_END = 13'(X_OFFSET + GRID_W * SQUARE_SIDE);
  localparam logic [12:0] Y_END = 13'(Y_OFFSET + GRID_H * SQUARE_SIDE);
  assign border = {hx < XO + STEP, hx + S + STEP > X_END,
                   hy < YO + STEP, hy + S + STEP > Y_END};
`else
  assign border = 4'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      col   <= '0;
      row   <= '0;
      d_col <= '0;
      d_row <= '0;
      d_vld <= 1'b0;
      hx    <= '0;
      hy    <= '0;
      acc   <= '0;
      flags <= '0;
      done  <= 1'b0;
    end else begin
      done  <= 1'b0;
      d_vld <= (state == SCAN);
      d_col <= col;
      d_row <= row;
      case (state)
        IDLE: begin
          if (start) begin
            hx  <= {1'b0, hero_x_pos};
            hy  <= {1'b0, hero_y_pos};
            acc <= '0;
          end
        end
        SCAN: begin
          acc <= acc | hit;
          if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? 4'd0 : row + 4'd1;
          end else begin
            col <= col + 4'd1;
          end
        end
        FLUSH: begin
          flags <= acc | hit | border;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign block_left  = flags[3];
  assign block_right = flags[2];
  assign block_up    = flags[1];
  assign block_down  = flags[0];

endmodule

// File: tb/tb_wall_scan_ctrl.sv
// Scoreboard bench for wall_scan_ctrl: a rectangle-overlap model predicts the flags of each accepted sweep.
module tb_wall_scan_ctrl;

  localparam int GW = 15, GH = 10, S = 60, XO = 62, YO = 108, STEP = 4;
  localparam int SWEEP = GW * GH + 2;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [11:0] hero_x_pos, hero_y_pos;
  logic        map_en, map_data = 1'b0, busy, done;
  logic [3:0]  map_col, map_row;
  logic        block_left, block_right, block_up, block_down;

  wall_scan_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .hero_x_pos(hero_x_pos), .hero_y_pos(hero_y_pos),
    .map_en(map_en), .map_col(map_col), .map_row(map_row), .map_data(map_data),
    .busy(busy), .done(done),
    .block_left(block_left), .block_right(block_right),
    .block_up(block_up), .block_down(block_down)
  );

  always #5 clk = ~clk;

  bit wall [GH][GW];
  always @(posedge clk) map_data <= map_en ? wall[map_row][map_col] : 1'b0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [3:0] flags; int done_cyc; } exp_t;
  exp_t q[$];
  logic [3:0] exp_flags = 4'b0;
  int n_checks = 0, n_fail = 0;
  int sweep_start = -1000;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit ov(int ax, int ay, int bx, int by);
    return (ax < bx + S) && (ax + S > bx) && (ay < by + S) && (ay + S > by);
  endfunction

  // Hero box moved one step in each direction, tested against every wall tile.
  function automatic logic [3:0] model(int hx, int hy);
    bit l = 0, r = 0, u = 0, d = 0;
    for (int rr = 0; rr < GH; rr++)
      for (int cc = 0; cc < GW; cc++)
        if (wall[rr][cc]) begin
          l |= ov(hx - STEP, hy, XO + S * cc, YO + S * rr);
          r |= ov(hx + STEP, hy, XO + S * cc, YO + S * rr);
          u |= ov(hx, hy - STEP, XO + S * cc, YO + S * rr);
          d |= ov(hx, hy + STEP, XO + S * cc, YO + S * rr);
        end
`ifdef WALL_SCAN_BORDER_EN
    l |= (hx - STEP < XO);
    r |= (hx + S + STEP > XO + GW * S);
    u |= (hy - STEP < YO);
    d |= (hy + S + STEP > YO + GH * S);
`endif
    return {l, r, u, d};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(int hx, int hy);
    exp_t e;
    hero_x_pos = 12'(hx);
    hero_y_pos = 12'(hy);
    start = 1'b1;
    if (cyc >= sweep_start + SWEEP) begin
      e.flags = model(hx, hy);
      e.done_cyc = cyc + SWEEP;
      q.push_back(e);
      sweep_start = cyc;
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle;
    int k = 0;
    while (q.size() != 0 && k < 400) begin
      tick();
      k++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", 32'd0, 32'd1);
      q.delete();
    end
    tick();
  endtask

  task automatic clear_map;
    for (int rr = 0; rr < GH; rr++)
      for (int cc = 0; cc < GW; cc++)
        wall[rr][cc] = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hero_x_pos = '0; hero_y_pos = '0;
    clear_map();
    fork
      begin : stimulus
        int c;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        issue_start(300, 300);
        wait_idle();

        wall[1][1] = 1'b1;
        issue_start(62, 168);
        wait_idle();

        clear_map();
        wall[1][0] = 1'b1;
        issue_start(62, 108);
        wait_idle();
        issue_start(62, 228);
        wait_idle();

        clear_map();
        issue_start(62, 108);
        wait_idle();

        // Restart attempts mid-sweep and in FLUSH are dropped; the one in the done cycle is taken.
        wall[4][7] = 1'b1;
        c = cyc;
        issue_start(482, 348);
        while (cyc < c + 50) tick();
        issue_start(482, 348);
        while (cyc < c + 151) tick();
        issue_start(482, 348);
        issue_start(482, 348);
        wait_idle();

        for (int it = 0; it < 6; it++) begin
          for (int rr = 0; rr < GH; rr++)
            for (int cc = 0; cc < GW; cc++)
              wall[rr][cc] = ($urandom_range(0, 7) == 0);
          issue_start($urandom_range(30, 1000), $urandom_range(60, 780));
          for (int k = 0; k < 160; k++) begin
            if ($urandom_range(0, 24) == 0)
              issue_start($urandom_range(0, 4095), $urandom_range(0, 4095));
            else begin
              hero_x_pos = 12'($urandom);
              hero_y_pos = 12'($urandom);
              tick();
            end
          end
          wait_idle();
        end

        // Reset mid-sweep with the hero sitting on a wall: no done, flags cleared.
        clear_map();
        wall[3][3] = 1'b1;
        c = cyc;
        issue_start(242, 288);
        while (cyc < c + 80) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sweep_start = -1000;
        repeat (200) tick();
        issue_start(242, 288);
        wait_idle();
        repeat (5) tick();
      end
      begin : monitor
        bit rst_prev;
        forever begin
          @(posedge clk);
          rst_prev = rst;
          if (rst) begin
            q.delete();
            exp_flags = 4'b0;
          end
          @(negedge clk);
          begin
            bit have, e_done, e_busy, e_en;
            int dc, idx;
            have = (q.size() != 0);
            dc = have ? q[0].done_cyc : -1000;
            e_done = have && (cyc == dc);
            e_busy = have && (cyc >= dc - (SWEEP - 1)) && (cyc < dc);
            e_en   = have && (cyc >= dc - (SWEEP - 1)) && (cyc <= dc - 2);
            chk("done", done, e_done);
            chk("busy", busy, e_busy);
            chk("map_en", map_en, e_en);
            if (rst_prev) begin
              chk("reset_col", map_col, 0);
              chk("reset_row", map_row, 0);
            end
            if (e_en) begin
              idx = cyc - (dc - (SWEEP - 1));
              chk("map_col", map_col, idx % GW);
              chk("map_row", map_row, idx / GW);
            end
            if (e_done) begin
              exp_flags = q[0].flags;
              void'(q.pop_front());
            end
            chk("flags", {block_left, block_right, block_up, block_down}, exp_flags);
          end
        end
      end
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
